// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage of the pipelined core.
// A request seen in IDLE is latched, held for LATENCY ACCESS cycles while the
// pipeline is stalled, performed on the last ACCESS edge, and reported in a
// single DONE cycle with BUSYWAIT low so the pipeline can advance.
module data_mem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q;
  logic [2:0]        func3_q;
  logic [31:0]       wdata_q;
  logic              wr_q;
  logic [31:0]       rdata_q;
  logic              latch_en;
  logic              do_op;

  logic [7:0]        mem [MEM_BYTES];

  // Address bits above the array size only cause wrap-around.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^ADDRESS[31:AW];

  // Byte indexes of the aligned word and halfword holding the latched address.
  logic [AW-1:0] w0_idx, w1_idx, w2_idx, w3_idx, h0_idx, h1_idx;
  assign w0_idx = {addr_q[AW-1:2], 2'b00};
  assign w1_idx = {addr_q[AW-1:2], 2'b01};
  assign w2_idx = {addr_q[AW-1:2], 2'b10};
  assign w3_idx = {addr_q[AW-1:2], 2'b11};
  assign h0_idx = {addr_q[AW-1:1], 1'b0};
  assign h1_idx = {addr_q[AW-1:1], 1'b1};

  logic [31:0] word_rd;
  assign word_rd = {mem[w3_idx], mem[w2_idx], mem[w1_idx], mem[w0_idx]};

  // Select the addressed lane of a little-endian word and extend it per funct3.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [31:0] word,
                                              input logic [1:0]  off);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    b_s = word[{off, 3'b000} +: 8];
    h_s = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return 32'(b_s);
      3'b001:  return 32'(h_s);
      3'b010:  return word;
      3'b100:  return {24'h0, b_s};
      3'b101:  return {16'h0, h_s};
      default: return 32'h0;
    endcase
  endfunction

  // Control state: FSM state and latency counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, stall request and the strobes that latch and perform the op.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    do_op    = 1'b0;
    BUSYWAIT = 1'b0;
    case (state_q)
      IDLE: begin
        BUSYWAIT = READ | WRITE;
        if (READ | WRITE) begin
          latch_en = 1'b1;
          cnt_d    = CNT_W'(LATENCY - 1);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        BUSYWAIT = 1'b1;
        if (cnt_q == '0) begin
          do_op   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request and registered load result; both cleared by reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q  <= '0;
      func3_q <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (latch_en) begin
        addr_q  <= ADDRESS[AW-1:0];
        func3_q <= FUNC3;
        wdata_q <= WRITEDATA;
        wr_q    <= WRITE;
      end
      if (do_op && !wr_q) begin
        rdata_q <= load_extend(func3_q, word_rd, addr_q[1:0]);
      end
    end
  end

  // Array stores; contents survive reset, and a reset mid-access drops the write.
  always_ff @(posedge CLK) begin
    if (do_op && wr_q && !RESET) begin
      case (func3_q)
        3'b000: mem[addr_q] <= wdata_q[7:0];
        3'b001: begin
          mem[h0_idx] <= wdata_q[7:0];
          mem[h1_idx] <= wdata_q[15:8];
        end
        3'b010: begin
          mem[w0_idx] <= wdata_q[7:0];
          mem[w1_idx] <= wdata_q[15:8];
          mem[w2_idx] <= wdata_q[23:16];
          mem[w3_idx] <= wdata_q[31:24];
        end
        default: ;
      endcase
    end
  end

  assign READDATA = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with MEM_BYTES=1024, LATENCY=4.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.MEM_BYTES(1024), .LATENCY(4)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .FUNC3(FUNC3),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Issue one request from IDLE (called at negedge+1); returns number of
  // BUSYWAIT-high cycles and READDATA seen in the DONE cycle, ends in IDLE.
  task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int drop_at, output int nbusy,
                     output logic [31:0] rd_done);
    READ = rd; WRITE = wr; FUNC3 = f3; ADDRESS = a; WRITEDATA = wd;
    #1;
    nbusy = 0;
    while (BUSYWAIT === 1'b1 && nbusy < 20) begin
      nbusy++;
      if (nbusy == drop_at) begin
        READ = 1'b0; WRITE = 1'b0; ADDRESS = 32'h0; WRITEDATA = 32'h0;
      end
      @(negedge CLK); #1;
    end
    rd_done = READDATA;
    READ = 1'b0; WRITE = 1'b0;
    @(negedge CLK); #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; FUNC3 = 3'b0;
    ADDRESS = 32'h0; WRITEDATA = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", BUSYWAIT); end
    checks++;
    if (READDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h expected 00000000", READDATA); end
    RESET = 1'b0;
    @(negedge CLK); #1;
  endtask

  task automatic test_word();
    int nb; logic [31:0] r;
    req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, nb, r);
    checks++;
    if (nb !== 5) begin errors++; $display("FAIL sw_stall got %0d expected 5", nb); end
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h expected 00000000", r); end
    req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, nb, r);
    checks++;
    if (nb !== 5) begin errors++; $display("FAIL lw_stall got %0d expected 5", nb); end
    checks++;
    if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_10 got %h expected deadbeef", r); end
  endtask

  task automatic test_byte();
    int nb; logic [31:0] r;
    req(1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, 0, nb, r);
    req(1'b0, 1'b1, 3'b000, 32'h21, 32'hFFFFFF80, 0, nb, r);
    checks++;
    if (nb !== 5) begin errors++; $display("FAIL sb_stall got %0d expected 5", nb); end
    req(1'b1, 1'b0, 3'b000, 32'h21, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_21 got %h expected ffffff80", r); end
    req(1'b1, 1'b0, 3'b100, 32'h21, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'h00000080) begin errors++; $display("FAIL lbu_21 got %h expected 00000080", r); end
    req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'h11228044) begin errors++; $display("FAIL lw_20 got %h expected 11228044", r); end
  endtask

  task automatic test_half();
    int nb; logic [31:0] r;
    req(1'b0, 1'b1, 3'b010, 32'h30, 32'hAAAAAAAA, 0, nb, r);
    req(1'b0, 1'b1, 3'b001, 32'h32, 32'h55558001, 0, nb, r);
    req(1'b1, 1'b0, 3'b001, 32'h32, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'hFFFF8001) begin errors++; $display("FAIL lh_32 got %h expected ffff8001", r); end
    req(1'b1, 1'b0, 3'b101, 32'h33, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'h00008001) begin errors++; $display("FAIL lhu_33 got %h expected 00008001", r); end
    req(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'h8001AAAA) begin errors++; $display("FAIL lw_30 got %h expected 8001aaaa", r); end
  endtask

  task automatic test_both_and_drop();
    int nb; logic [31:0] r;
    req(1'b1, 1'b1, 3'b010, 32'h40, 32'h12345678, 3, nb, r);
    checks++;
    if (nb !== 5) begin errors++; $display("FAIL both_stall got %0d expected 5", nb); end
    checks++;
    if (r !== 32'h8001AAAA) begin errors++; $display("FAIL both_rdata got %h expected 8001aaaa", r); end
    req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'h12345678) begin errors++; $display("FAIL lw_40 got %h expected 12345678", r); end
  endtask

  task automatic test_reset_mid_access();
    int nb; logic [31:0] r;
    req(1'b0, 1'b1, 3'b010, 32'h50, 32'h11111111, 0, nb, r);
    req(1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'h11111111) begin errors++; $display("FAIL lw_50_pre got %h expected 11111111", r); end
    WRITE = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h50; WRITEDATA = 32'hAAAAAAAA;
    @(negedge CLK); #1;
    @(negedge CLK); #1;
    RESET = 1'b1; WRITE = 1'b0;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", BUSYWAIT); end
    checks++;
    if (READDATA !== 32'h0) begin errors++; $display("FAIL midrst_rdata got %h expected 00000000", READDATA); end
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL midrst_busy_hold got %b expected 0", BUSYWAIT); end
    RESET = 1'b0;
    @(negedge CLK); #1;
    req(1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'h11111111) begin errors++; $display("FAIL lw_50_post got %h expected 11111111", r); end
  endtask

  task automatic test_wrap_and_bad_func3();
    int nb; logic [31:0] r;
    req(1'b1, 1'b0, 3'b010, 32'd1024 + 32'h10, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_wrap got %h expected deadbeef", r); end
    req(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 0, nb, r);
    checks++;
    if (nb !== 5) begin errors++; $display("FAIL f3_011_stall got %0d expected 5", nb); end
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL f3_011_load got %h expected 00000000", r); end
    req(1'b0, 1'b1, 3'b011, 32'h10, 32'h0, 0, nb, r);
    checks++;
    if (nb !== 5) begin errors++; $display("FAIL f3_011_store_stall got %0d expected 5", nb); end
    req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, nb, r);
    checks++;
    if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_after_f3_011 got %h expected deadbeef", r); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_both_and_drop();
    test_reset_mid_access();
    test_wrap_and_bad_func3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
